// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the fft_frame_sched scheduler and its tag FIFO.
package fft_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Default complex sample layout handed to the streaming FFT core
  localparam int SAMPLE_DW = 16;

  typedef struct packed {
    logic [SAMPLE_DW-1:0] re;
    logic [SAMPLE_DW-1:0] im;
  } sample_t;

  // Bits needed to hold a channel index (never narrower than one bit)
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_sched_tag_fifo.sv
// Small synchronous FIFO holding the channel id of every frame accepted by
// the FFT core but not yet fully output. Push and pop in the same cycle are
// both honoured. The head is read combinationally so the id lines up with
// the core output sample it labels.
module fft_sched_tag_fifo
  import fft_sched_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = ch_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame-level round-robin scheduler sharing one streaming FFT core between
// N_CH sources, and tagging each core output frame with its source channel.
// Optional per-channel statistics counters: define FFT_FRAME_SCHED_STATS_EN.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int FFT_SIZE     = 256,
  parameter int DW           = 16,
  parameter int GAP_CYCLES   = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         ch_req,
  output logic [N_CH-1:0]         ch_grant,
  input  logic [N_CH*DW-1:0]      ch_re,
  input  logic [N_CH*DW-1:0]      ch_im,
  input  logic [N_CH-1:0]         ch_valid,
  output logic [DW-1:0]           fft_din_re,
  output logic [DW-1:0]           fft_din_im,
  output logic                    fft_din_valid,
  input  logic                    fft_dout_valid,
  output logic [ch_w(N_CH)-1:0]   out_ch_id,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    underrun,
  output logic                    orphan_err,
  output logic                    busy
`ifdef FFT_FRAME_SCHED_STATS_EN
  ,
  output logic [N_CH*16-1:0]      frames_cnt,
  output logic [N_CH*16-1:0]      underrun_cnt
`endif
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int CNT_W = ch_w(FFT_SIZE);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  state_t            state_reg;
  logic [CH_W-1:0]   ptr_reg;
  logic [CH_W-1:0]   cur_ch_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [N_CH-1:0]   grant_reg;
  logic [DW-1:0]     din_re_reg;
  logic [DW-1:0]     din_im_reg;
  logic              din_valid_reg;
  logic              underrun_reg;
  logic [CNT_W-1:0]  outcnt_reg;
  logic              orphan_reg;

  logic [DW-1:0]     lane_re [N_CH];
  logic [DW-1:0]     lane_im [N_CH];
  logic              arb_found;
  logic [CH_W-1:0]   arb_ch;
  logic              tag_push;
  logic              tag_pop;
  logic              tag_full;
  logic              tag_empty;
  logic [CH_W-1:0]   tag_head;

  // Unpack the per-channel sample buses into lanes
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_lane
      assign lane_re[gi] = ch_re[gi*DW +: DW];
      assign lane_im[gi] = ch_im[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search from ptr_reg; descending loop so the nearest requester wins
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_req[(int'(ptr_reg) + i) % N_CH]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'((int'(ptr_reg) + i) % N_CH);
      end
    end
  end

  assign tag_push = (state_reg == IDLE) && arb_found && !tag_full;

  // Scheduler FSM with registered grant and core-input sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cur_ch_reg    <= '0;
      cnt_reg       <= '0;
      gap_cnt_reg   <= '0;
      grant_reg     <= '0;
      din_re_reg    <= '0;
      din_im_reg    <= '0;
      din_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      din_valid_reg <= 1'b0;
      din_re_reg    <= '0;
      din_im_reg    <= '0;
      underrun_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tag_push) begin
            cur_ch_reg <= arb_ch;
            ptr_reg    <= CH_W'((int'(arb_ch) + 1) % N_CH);
            grant_reg  <= N_CH'(1) << arb_ch;
            cnt_reg    <= '0;
            state_reg  <= STREAM;
          end
        end
        STREAM: begin
          // A missing sample is replaced by zero so the frame stays contiguous
          din_valid_reg <= 1'b1;
          if (ch_valid[cur_ch_reg]) begin
            din_re_reg <= lane_re[cur_ch_reg];
            din_im_reg <= lane_im[cur_ch_reg];
          end else begin
            underrun_reg <= 1'b1;
          end
          if (cnt_reg == CNT_W'(FFT_SIZE - 1)) begin
            cnt_reg     <= '0;
            grant_reg   <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (int'(gap_cnt_reg) >= GAP_CYCLES - 1) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output-side frame position and sticky orphan detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outcnt_reg <= '0;
      orphan_reg <= 1'b0;
    end else if (fft_dout_valid) begin
      outcnt_reg <= (outcnt_reg == CNT_W'(FFT_SIZE - 1)) ? '0 : outcnt_reg + 1'b1;
      if (tag_empty) begin
        orphan_reg <= 1'b1;
      end
    end
  end

  assign tag_pop = out_eof;

  fft_sched_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (arb_ch),
    .pop       (tag_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

  assign ch_grant      = grant_reg;
  assign fft_din_re    = din_re_reg;
  assign fft_din_im    = din_im_reg;
  assign fft_din_valid = din_valid_reg;
  assign underrun      = underrun_reg;
  assign orphan_err    = orphan_reg;
  assign busy          = (state_reg != IDLE);
  assign out_ch_id     = tag_empty ? '0 : tag_head;
  assign out_sof       = fft_dout_valid && (outcnt_reg == '0);
  assign out_eof       = fft_dout_valid && (outcnt_reg == CNT_W'(FFT_SIZE - 1));

`ifdef FFT_FRAME_SCHED_STATS_EN
  // Per-channel granted-frame and substituted-sample counters, wrapping
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_stats
      logic [15:0] frames_reg;
      logic [15:0] underruns_reg;

      // Count grants issued to and samples substituted for this channel
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          frames_reg    <= '0;
          underruns_reg <= '0;
        end else begin
          if (tag_push && (arb_ch == CH_W'(gi))) begin
            frames_reg <= frames_reg + 1'b1;
          end
          if ((state_reg == STREAM) && (cur_ch_reg == CH_W'(gi)) && !ch_valid[gi]) begin
            underruns_reg <= underruns_reg + 1'b1;
          end
        end
      end

      assign frames_cnt[gi*16 +: 16]   = frames_reg;
      assign underrun_cnt[gi*16 +: 16] = underruns_reg;
    end
  endgenerate
`endif

endmodule
